cxu_cmd_initiator: RTL

//  CPU-side initiator for the CXU cmd/rsp protocol; drives the cmd_* bus into a CXU responder and collects rsp_*.

---
 rtl/cxu_pkg.sv | 27 ++
 rtl/cxu_cmd_fifo.sv | 47 ++++
 rtl/cxu_cmd_initiator.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cxu_pkg.sv
// Shared types for the CXU cmd/rsp initiator: FSM state encoding and the
// packed command record held in the command FIFO.
package cxu_pkg;

  localparam int unsigned CXU_FUNC_W  = 3;
  localparam int unsigned CXU_STATE_W = 3;
  localparam int unsigned CXU_ID_W    = 4;
  localparam int unsigned CXU_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    HOLD_RSP
  } cxu_state_e;

  typedef struct packed {
    logic [CXU_FUNC_W-1:0]  function_id;
    logic [CXU_DATA_W-1:0]  inputs_0;
    logic [CXU_DATA_W-1:0]  inputs_1;
    logic [CXU_STATE_W-1:0] state_id;
    logic [CXU_ID_W-1:0]    cxu_id;
  } cxu_cmd_t;

  localparam int unsigned CXU_CMD_W = $bits(cxu_cmd_t);

endpackage

// File: rtl/cxu_cmd_fifo.sv
// Synchronous command FIFO; head is shown combinationally so the issued
// payload stays stable until the entry is popped.
module cxu_cmd_fifo
  import cxu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  cxu_cmd_t i_data,
  input  logic     i_pop,
  output logic     o_full,
  output logic     o_empty,
  output cxu_cmd_t o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  cxu_cmd_t        r_mem [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic            w_wr;
  logic            w_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/cxu_cmd_initiator.sv
// CPU-side CXU initiator: queues requests, issues one command at a time,
// returns each response or a timeout error on the result port.
module cxu_cmd_initiator
  import cxu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CXU_FUNC_W-1:0]  req_function_id,
  input  logic [CXU_STATE_W-1:0] req_state_id,
  input  logic [CXU_ID_W-1:0]    req_cxu_id,
  input  logic [CXU_DATA_W-1:0]  req_inputs_0,
  input  logic [CXU_DATA_W-1:0]  req_inputs_1,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CXU_DATA_W-1:0]  res_data,
  output logic                   res_error,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [CXU_FUNC_W-1:0]  cmd_payload_function_id,
  output logic [CXU_DATA_W-1:0]  cmd_payload_inputs_0,
  output logic [CXU_DATA_W-1:0]  cmd_payload_inputs_1,
  output logic [CXU_STATE_W-1:0] cmd_payload_state_id,
  output logic [CXU_ID_W-1:0]    cmd_payload_cxu_id,
  output logic                   cmd_payload_ready,
  input  logic                   rsp_valid,
  output logic                   rsp_ready,
  input  logic [CXU_DATA_W-1:0]  rsp_payload_outputs_0,
  input  logic                   rsp_payload_ready,
  output logic                   busy,
  output logic [15:0]            issued_count
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  cxu_state_e             r_state;
  logic [TMR_W-1:0]       r_timer;
  logic [CXU_DATA_W-1:0]  r_res_data;
  logic                   r_res_error;
  logic [15:0]            r_issued_count;

  cxu_cmd_t w_req_cmd;
  cxu_cmd_t w_head;
  logic     w_full;
  logic     w_empty;
  logic     w_push;
  logic     w_pop;
  logic     w_in_flight;
  logic     w_cmd_fire;
  logic     w_capture;
  logic     w_timeout;
  logic     w_unused_rsp_payload_ready;

  assign w_unused_rsp_payload_ready = rsp_payload_ready;

  assign w_req_cmd = '{function_id: req_function_id, inputs_0: req_inputs_0,
                       inputs_1: req_inputs_1, state_id: req_state_id,
                       cxu_id: req_cxu_id};

  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;

  assign w_in_flight = (r_state == ISSUE) || (r_state == WAIT_RSP);
  assign w_cmd_fire  = (r_state == ISSUE) && cmd_ready;
  assign w_capture   = (w_cmd_fire && rsp_valid) || ((r_state == WAIT_RSP) && rsp_valid);
  assign w_timeout   = w_in_flight && (r_timer == TMR_LAST) && !w_capture;
  // Timeout while still in ISSUE discards the head that was never accepted.
  assign w_pop       = (r_state == ISSUE) && (cmd_ready || w_timeout);

  cxu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_req_cmd),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_timer        <= '0;
      r_res_data     <= '0;
      r_res_error    <= 1'b0;
      r_issued_count <= '0;
    end else begin
      if (w_cmd_fire)  r_issued_count <= r_issued_count + 16'd1;
      if (w_in_flight) r_timer        <= r_timer + TMR_W'(1);
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state <= ISSUE;
            r_timer <= '0;
          end
        end
        ISSUE, WAIT_RSP: begin
          if (w_capture) begin
            r_state     <= HOLD_RSP;
            r_res_data  <= rsp_payload_outputs_0;
            r_res_error <= 1'b0;
          end else if (w_timeout) begin
            r_state     <= HOLD_RSP;
            r_res_data  <= '0;
            r_res_error <= 1'b1;
          end else if (w_cmd_fire) begin
            r_state <= WAIT_RSP;
          end
        end
        HOLD_RSP: begin
          if (res_ready) begin
            if (!w_empty) begin
              r_state <= ISSUE;
              r_timer <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_valid               = (r_state == ISSUE);
  assign rsp_ready               = w_in_flight;
  assign cmd_payload_ready       = w_in_flight;
  assign cmd_payload_function_id = w_head.function_id;
  assign cmd_payload_inputs_0    = w_head.inputs_0;
  assign cmd_payload_inputs_1    = w_head.inputs_1;
  assign cmd_payload_state_id    = w_head.state_id;
  assign cmd_payload_cxu_id      = w_head.cxu_id;
  assign res_valid               = (r_state == HOLD_RSP);
  assign res_data                = r_res_data;
  assign res_error               = r_res_error;
  assign busy                    = (r_state != IDLE) || !w_empty;
  assign issued_count            = r_issued_count;

endmodule
